// File: rtl/scene_pkg.sv
// Shared scene encodings, default frame timings and widths for the scene sequencer.
package scene_pkg;

  typedef enum logic [2:0] {
    S_OPEN      = 3'd0,
    S_SERVE     = 3'd1,
    S_PLAY      = 3'd2,
    S_LOST      = 3'd3,
    S_GAME_OVER = 3'd4,
    S_WIN       = 3'd5
  } scene_state_t;

  localparam int DEF_NUM_LIVES    = 3;
  localparam int DEF_SERVE_FRAMES = 30;
  localparam int DEF_LOST_FRAMES  = 60;
  localparam int DEF_MSG_FRAMES   = 240;
  localparam int DEF_BLINK_FRAMES = 16;

  localparam int LIVES_W     = 2;
  localparam int FRAME_CNT_W = 8;

endpackage

// File: rtl/scene_sequencer_frame_timer.sv
// Per-scene frame counter (saturating, cleared on scene entry) and message blink phase.
module frame_timer
  import scene_pkg::*;
#(
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   i_clear,
  input  logic                   i_sof,
  output logic [FRAME_CNT_W-1:0] o_count,
  output logic                   o_blink,
  output logic                   o_blinkNext
);

  localparam logic [FRAME_CNT_W-1:0] BLINK_LEN  = FRAME_CNT_W'(BLINK_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] BLINK_LAST = FRAME_CNT_W'(BLINK_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] CNT_MAX    = '1;

  logic [FRAME_CNT_W-1:0] r_count;
  logic                   r_blink;
  logic                   w_toggle;

  assign w_toggle = i_sof && ((r_count % BLINK_LEN) == BLINK_LAST);

  // The next blink value is exported so the parent can register its message enables
  always_comb begin
    o_blinkNext = r_blink;
    if (i_clear)
      o_blinkNext = 1'b1;
    else if (w_toggle)
      o_blinkNext = ~r_blink;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_count <= '0;
      r_blink <= 1'b1;
    end else begin
      if (i_clear)
        r_count <= '0;
      else if (i_sof && (r_count != CNT_MAX))
        r_count <= r_count + 1'b1;
      r_blink <= o_blinkNext;
    end
  end

  assign o_count = r_count;
  assign o_blink = r_blink;

endmodule

// File: rtl/scene_sequencer.sv
// Game scene controller: sequences open/serve/play/lost/game-over/win, owns the lives
// count and gates the overlay and playfield drawing requests.
module scene_sequencer
  import scene_pkg::*;
#(
  parameter int NUM_LIVES    = DEF_NUM_LIVES,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int LOST_FRAMES  = DEF_LOST_FRAMES,
  parameter int MSG_FRAMES   = DEF_MSG_FRAMES,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               i_startOfFrame,
  input  logic               i_startKey,
  input  logic               i_ballLost,
  input  logic               i_winReached,
  output logic               o_showOpen,
  output logic               o_showGameOver,
  output logic               o_showWin,
  output logic               o_playEnable,
  output logic               o_newBallReq,
  output logic [LIVES_W-1:0] o_livesLeft,
  output logic [2:0]         o_sceneState
);

  localparam logic [FRAME_CNT_W-1:0] SERVE_LAST = FRAME_CNT_W'(SERVE_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] LOST_LAST  = FRAME_CNT_W'(LOST_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] MSG_LAST   = FRAME_CNT_W'(MSG_FRAMES - 1);
  localparam logic [LIVES_W-1:0]     LIVES_FULL = LIVES_W'(NUM_LIVES);

  scene_state_t           r_state;
  scene_state_t           w_next;
  logic [LIVES_W-1:0]     r_lives;
  logic [LIVES_W-1:0]     w_livesNext;
  logic                   r_keyPrev;
  logic                   r_keyArmed;
  logic                   w_startEdge;
  logic                   w_enter;
  logic [FRAME_CNT_W-1:0] w_count;
  logic                   w_blink;
  logic                   w_blinkNext;
  logic                   r_showOpen;
  logic                   r_showGameOver;
  logic                   r_showWin;
  logic                   r_playEnable;
  logic                   r_newBallReq;

  // A key already held when reset releases must be seen low once before it can start a game
  assign w_startEdge = r_keyArmed && i_startKey && !r_keyPrev;

  always_comb begin
    w_next      = r_state;
    w_livesNext = r_lives;
    unique case (r_state)
      S_OPEN: begin
        if (w_startEdge) begin
          w_next      = S_SERVE;
          w_livesNext = LIVES_FULL;
        end
      end
      S_SERVE: begin
        if (i_startOfFrame && (w_count == SERVE_LAST))
          w_next = S_PLAY;
      end
      S_PLAY: begin
        if (i_winReached) begin
          w_next = S_WIN;
        end else if (i_ballLost) begin
          w_next = S_LOST;
          if (r_lives != '0)
            w_livesNext = r_lives - 1'b1;
        end
      end
      S_LOST: begin
        if (i_startOfFrame && (w_count == LOST_LAST))
          w_next = (r_lives != '0) ? S_SERVE : S_GAME_OVER;
      end
      S_GAME_OVER, S_WIN: begin
        if (w_startEdge || (i_startOfFrame && (w_count == MSG_LAST)))
          w_next = S_OPEN;
      end
      default: w_next = S_OPEN;
    endcase
  end

  assign w_enter = (w_next != r_state);

  frame_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_frame_timer (
    .clk        (clk),
    .resetN     (resetN),
    .i_clear    (w_enter),
    .i_sof      (i_startOfFrame),
    .o_count    (w_count),
    .o_blink    (w_blink),
    .o_blinkNext(w_blinkNext)
  );

  // Enables are decoded from the next state so every output comes straight off a flop
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state        <= S_OPEN;
      r_lives        <= LIVES_FULL;
      r_keyPrev      <= 1'b0;
      r_keyArmed     <= 1'b0;
      r_showOpen     <= 1'b1;
      r_showGameOver <= 1'b0;
      r_showWin      <= 1'b0;
      r_playEnable   <= 1'b0;
      r_newBallReq   <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_lives        <= w_livesNext;
      r_keyPrev      <= i_startKey;
      r_keyArmed     <= 1'b1;
      r_showOpen     <= (w_next == S_OPEN);
      r_showGameOver <= (w_next == S_GAME_OVER) && w_blinkNext;
      r_showWin      <= (w_next == S_WIN) && w_blinkNext;
      r_playEnable   <= (w_next == S_PLAY) || (w_next == S_LOST);
      r_newBallReq   <= (r_state == S_SERVE) && (w_next == S_PLAY);
    end
  end

  assign o_showOpen     = r_showOpen;
  assign o_showGameOver = r_showGameOver;
  assign o_showWin      = r_showWin;
  assign o_playEnable   = r_playEnable;
  assign o_newBallReq   = r_newBallReq;
  assign o_livesLeft    = r_lives;
  assign o_sceneState   = r_state;

endmodule

// File: doc/scene_sequencer.md
Name: scene_sequencer

Overview:
- Game-level scene controller that decides which overlay and playfield layers the VGA object priority mux may show, and when.
- Sequences open screen -> serve -> play -> ball-lost -> game-over/win, owns the lives count, and times every scene in video frames.
- Its show*/playEnable outputs gate the message and object drawing-request lines before they enter the mux.

Parameters:
- NUM_LIVES, 3, balls per game (1..3).
- SERVE_FRAMES, 30, frames between entering SERVE and the new-ball request.
- LOST_FRAMES, 60, frames spent in LOST before the next decision.
- MSG_FRAMES, 240, frames a game-over/win message stays before auto-return to OPEN.
- BLINK_FRAMES, 16, half-period in frames of the message blink.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- startOfFrame  in  1  one-clk pulse per video frame.
- startKey  in  1  debounced start button level, active high.
- ballLost  in  1  one-clk pulse: ball left the playfield.
- winReached  in  1  level: score reached the win threshold.
- showOpen  out  1  enable for the open-message drawing request.
- showGameOver  out  1  enable for the game-over drawing request (blinking).
- showWin  out  1  enable for the win-message drawing request (blinking).
- playEnable  out  1  enable for ball/flipper/obstacle drawing requests and physics.
- newBallReq  out  1  one-clk pulse: place a ball at the cannon.
- livesLeft  out  2  remaining balls.
- sceneState  out  3  current state encoding, for the score and debug logic.

Behaviour:
- Reset is asynchronous and active-low; clock is clk. All outputs are registered.
- Reset values: state OPEN, showOpen=1, all other show*/playEnable/newBallReq=0, livesLeft=NUM_LIVES, frame counter=0, blink phase=1.
- startKey rising-edge detection: previous-level register, reset value 0. A key held through reset does not count as an edge.
- Frame counter: 8 bits. Cleared on every state entry. Increments on startOfFrame and saturates at 255.
- State encodings: OPEN=0, SERVE=1, PLAY=2, LOST=3, GAME_OVER=4, WIN=5.
- Transitions, taken on the clk edge after the qualifying event:
  - OPEN: start edge -> SERVE; livesLeft loads NUM_LIVES.
  - SERVE: when startOfFrame arrives and counter==SERVE_FRAMES-1, -> PLAY; newBallReq pulses for exactly that one transition clock.
  - PLAY, priority order:
    - winReached -> WIN.
    - otherwise ballLost -> LOST; livesLeft decrements in the same edge and never goes below 0.
  - LOST: when startOfFrame arrives and counter==LOST_FRAMES-1: if livesLeft!=0 -> SERVE, else -> GAME_OVER.
  - GAME_OVER / WIN: start edge, or startOfFrame with counter==MSG_FRAMES-1 -> OPEN.
- Output decode per state:
  - showOpen is 1 only in OPEN.
  - playEnable is 1 in PLAY and LOST; the playfield stays visible while the ball falls.
  - Blink phase toggles on each startOfFrame where counter mod BLINK_FRAMES == BLINK_FRAMES-1, and resets to 1 on state entry.
  - showGameOver = (state==GAME_OVER) & blink phase.
  - showWin = (state==WIN) & blink phase.
- Simultaneous events:
  - winReached and ballLost in the same PLAY clock -> WIN; lives are not decremented.
  - ballLost outside PLAY is ignored.
  - winReached outside PLAY is ignored.
  - A start edge in SERVE, PLAY or LOST is ignored.
- Reset mid-game: returns immediately to OPEN with full lives; no newBallReq is emitted.
- The mux keeps its fixed priority order. This block only gates the request lines, so at most one message enable is ever high.

Decomposition:
- scene_pkg holds:
  - the scene_state_t enum with the encodings above;
  - default frame constants;
  - the LIVES_W=2 width constant.
- One sub-module, frame_timer: the 8-bit saturating frame counter with a clear input and a blink-phase generator. Instantiated once inside scene_sequencer.

Test Plan:
- Reset, then hold startKey high through the reset release -> state stays OPEN; showOpen=1 and livesLeft=3. Release then press -> SERVE.
- Start, then 30 startOfFrame pulses -> exactly one newBallReq on the clk entering PLAY; playEnable=1 and showOpen=0.
- In PLAY, three ballLost pulses, each followed by 60 frames and re-serve -> livesLeft 2,1,0; after the third LOST window, state GAME_OVER. showGameOver toggles every 16 frames; after 240 frames, state OPEN.
- In PLAY, raise winReached and ballLost in the same clock -> WIN with livesLeft unchanged. A start edge at frame 5 -> OPEN.
- Assert resetN low mid-LOST -> asynchronous return to OPEN; livesLeft=3 and newBallReq=0 throughout.
- With BLINK_FRAMES=4, MSG_FRAMES=10 -> blink sequence 1,0,1 at frame boundaries 4 and 8; exit to OPEN at frame 10.
